// File: rtl/mdio_apb_arbiter.sv
// Round-robin arbiter sharing one mdio_if_apb master port between NREQ
// requesters. A requester may lock the bus across several transfers, for
// example an indirect 0x1E/0x1F read-modify-write. The lock is released when
// the holder's last transfer completes with s_plock=0. It is also released
// after LOCK_TMO idle cycles, and lock_err pulses in that case.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | no owner; next request chosen round-robin starting at r_ptr
// ISSUE | transfer presented on m_*, waiting for m_pready
// DONE  | one-cycle completion, s_pready[grant] and s_prdata valid
// HOLD  | bus locked to grant; only s_psel[grant] is considered
`timescale 1ns/1ps

module mdio_apb_arbiter #(
  parameter int NREQ     = 3,
  parameter int LOCK_TMO = 1024,
  localparam int GW      = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      s_psel,
  input  logic [NREQ-1:0]      s_plock,
  input  logic [NREQ-1:0]      s_pwrite,
  input  logic [16*NREQ-1:0]   s_paddr,
  input  logic [16*NREQ-1:0]   s_pwdata,
  output logic [15:0]          s_prdata,
  output logic [NREQ-1:0]      s_pready,
  output logic                 m_psel,
  output logic                 m_pwrite,
  output logic [15:0]          m_paddr,
  output logic [15:0]          m_pwdata,
  input  logic [15:0]          m_prdata,
  input  logic                 m_pready,
  output logic [GW-1:0]        grant,
  output logic                 locked,
  output logic                 lock_err
);

  localparam int TMO_W = $clog2(LOCK_TMO);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_DONE, ST_HOLD} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [GW-1:0]     r_ptr;
  logic [GW-1:0]     r_grant;
  logic [TMO_W-1:0]  r_tmo;
  logic              r_lk;
  logic              r_m_psel;
  logic              r_m_pwrite;
  logic [15:0]       r_m_paddr;
  logic [15:0]       r_m_pwdata;
  logic [15:0]       r_s_prdata;
  logic              w_found;
  logic [GW-1:0]     w_win;
  logic              w_tmo_end;
  logic              w_lock_err;

  // Requester index that is off positions after base, with wrap at NREQ.
  function automatic logic [GW-1:0] rr_idx(input logic [GW-1:0] base, input int off);
    int sum;
    sum = int'(base) + off;
    if (sum >= NREQ) sum = sum - NREQ;
    return GW'(sum);
  endfunction

  function automatic logic [GW-1:0] next_idx(input logic [GW-1:0] g);
    return (g == GW'(NREQ - 1)) ? '0 : g + 1'b1;
  endfunction

  assign w_tmo_end = (r_tmo == TMO_W'(LOCK_TMO - 1));

  // Round-robin winner search; the loop runs backwards so the lowest offset wins.
  always_comb begin
    w_found = 1'b0;
    w_win   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (s_psel[rr_idx(r_ptr, k)]) begin
        w_found = 1'b1;
        w_win   = rr_idx(r_ptr, k);
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state decode and the lock timeout pulse.
  always_comb begin
    w_state_nxt = r_state;
    w_lock_err  = 1'b0;
    case (r_state)
      ST_IDLE:  if (w_found) w_state_nxt = ST_ISSUE;
      ST_ISSUE: if (m_pready) w_state_nxt = ST_DONE;
      ST_DONE:  w_state_nxt = r_lk ? ST_HOLD : ST_IDLE;
      ST_HOLD: begin
        if (s_psel[r_grant]) begin
          w_state_nxt = ST_ISSUE;
        end else if (w_tmo_end) begin
          w_lock_err  = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Grant, pointer, lock timer and the m_*/s_prdata registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr      <= '0;
      r_grant    <= '0;
      r_tmo      <= '0;
      r_lk       <= 1'b0;
      r_m_psel   <= 1'b0;
      r_m_pwrite <= 1'b0;
      r_m_paddr  <= '0;
      r_m_pwdata <= '0;
      r_s_prdata <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_tmo <= '0;
          if (w_found) begin
            r_grant    <= w_win;
            r_m_psel   <= 1'b1;
            r_m_pwrite <= s_pwrite[w_win];
            r_m_paddr  <= s_paddr[int'(w_win)*16 +: 16];
            r_m_pwdata <= s_pwdata[int'(w_win)*16 +: 16];
          end
        end
        ST_ISSUE: begin
          r_tmo <= '0;
          if (m_pready) begin
            r_s_prdata <= m_prdata;
            r_m_psel   <= 1'b0;
            r_lk       <= s_plock[r_grant];
          end
        end
        ST_DONE: begin
          r_tmo <= '0;
          if (!r_lk) r_ptr <= next_idx(r_grant);
        end
        ST_HOLD: begin
          if (s_psel[r_grant]) begin
            r_tmo      <= '0;
            r_m_psel   <= 1'b1;
            r_m_pwrite <= s_pwrite[r_grant];
            r_m_paddr  <= s_paddr[int'(r_grant)*16 +: 16];
            r_m_pwdata <= s_pwdata[int'(r_grant)*16 +: 16];
          end else if (w_tmo_end) begin
            r_tmo <= '0;
            r_ptr <= next_idx(r_grant);
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end
        default: r_tmo <= '0;
      endcase
    end
  end

  assign s_pready = (r_state == ST_DONE) ? (NREQ'(1) << r_grant) : '0;
  assign s_prdata = r_s_prdata;
  assign m_psel   = r_m_psel;
  assign m_pwrite = r_m_pwrite;
  assign m_paddr  = r_m_paddr;
  assign m_pwdata = r_m_pwdata;
  assign grant    = r_grant;
  assign locked   = (r_state == ST_HOLD);
  assign lock_err = w_lock_err;

endmodule
